// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, flag bit positions
// and the rule deciding which flags an instruction may update.
package ex_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_PASSB = 5'd8;
    localparam logic [4:0] OP_MUL   = 5'd9;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

    // Flag vector layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    function automatic logic [2:0] flag_mask(input logic is_arith, input logic is_mem);
        logic [2:0] m;
        m = '0;
        if (!is_mem) begin
            m[FLAG_Z] = 1'b1;
            m[FLAG_V] = is_arith;
            m[FLAG_N] = is_arith;
        end
        return m;
    endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative multiplier retiring MUL_BITS multiplier bits per cycle; the low DATA_W
// product bits are valid on o_prod while o_last is high during a step.
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_prod
);

    localparam int MUL_LAT = DATA_W / MUL_BITS;
    localparam int CNT_W   = $clog2(MUL_LAT + 1);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_part;

    // r_a is pre-shifted each step so the partial product is already aligned
    assign w_part = r_a * DATA_W'(r_b[MUL_BITS-1:0]);
    assign o_prod = r_acc + w_part;
    assign o_last = (r_cnt == CNT_W'(MUL_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_a   <= r_a << MUL_BITS;
            r_b   <= r_b >> MUL_BITS;
            r_acc <= o_prod;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: MEM/WB forwarding, load-use stall, ALU + flags, 1-cycle registered EX/MEM outputs.
// Define EX_MUL_EN to add the iterative multiplier (stalls ID/EX until the product registers).
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int OP_W     = 5,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_in,
    input  logic              ex_flush_in,
    input  logic              mem_stall_in,
    input  logic [OP_W-1:0]   ex_aluop,
    input  logic              ex_alusrc,
    input  logic [DATA_W-1:0] ex_reg_1,
    input  logic [DATA_W-1:0] ex_reg_2,
    input  logic [DATA_W-1:0] ex_imm,
    input  logic [REG_AW-1:0] ex_regrdaddr1_in,
    input  logic [REG_AW-1:0] ex_regrdaddr2_in,
    input  logic [REG_AW-1:0] ex_regwraddr_in,
    input  logic              ex_regwrite_in,
    input  logic              ex_memtoreg_in,
    input  logic              ex_bustoreg_in,
    input  logic              ex_memread_in,
    input  logic              ex_memwrite_in,
    input  logic              mem_regwrite_in,
    input  logic              mem_memread_in,
    input  logic [REG_AW-1:0] mem_regwraddr_in,
    input  logic [DATA_W-1:0] mem_regwrdata_in,
    input  logic              wb_regwrite_in,
    input  logic [REG_AW-1:0] wb_regwraddr_in,
    input  logic [DATA_W-1:0] wb_regwrdata_in,
    output logic              ex_stall_out,
    output logic              ex_valid_out,
    output logic [2:0]        ex_flag_out,
    output logic              ex_regwrite_out,
    output logic              ex_memtoreg_out,
    output logic              ex_bustoreg_out,
    output logic              ex_memread_out,
    output logic              ex_memwrite_out,
    output logic [DATA_W-1:0] ex_alu_out,
    output logic [DATA_W-1:0] ex_alu_src2_out,
    output logic [REG_AW-1:0] ex_regwraddr_out
);

    localparam int MSB  = DATA_W - 1;
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] L_ADD   = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] L_SUB   = OP_W'(OP_SUB);
    localparam logic [OP_W-1:0] L_AND   = OP_W'(OP_AND);
    localparam logic [OP_W-1:0] L_OR    = OP_W'(OP_OR);
    localparam logic [OP_W-1:0] L_XOR   = OP_W'(OP_XOR);
    localparam logic [OP_W-1:0] L_SLL   = OP_W'(OP_SLL);
    localparam logic [OP_W-1:0] L_SRL   = OP_W'(OP_SRL);
    localparam logic [OP_W-1:0] L_SRA   = OP_W'(OP_SRA);
    localparam logic [OP_W-1:0] L_PASSB = OP_W'(OP_PASSB);

    logic              w_mem_hit_a, w_mem_hit_b, w_wb_hit_a, w_wb_hit_b;
    logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_opb;
    logic              w_load_use;
    logic [DATA_W-1:0] w_alu_res, w_res;
    logic              w_ovf;
    logic [2:0]        w_flag_calc, w_flag_mask, w_flag_nxt;
    logic              w_take;
    logic              w_is_mul, w_mul_busy, w_mul_done, w_mul_stall;
    logic [DATA_W-1:0] w_mul_prod;

    logic              r_valid, r_regwrite, r_memtoreg, r_bustoreg, r_memread, r_memwrite;
    logic [DATA_W-1:0] r_alu, r_src2;
    logic [REG_AW-1:0] r_wraddr;
    logic [2:0]        r_flag;

    // MEM is the younger producer, so it wins over WB for the same address
    assign w_mem_hit_a = mem_regwrite_in && (mem_regwraddr_in == ex_regrdaddr1_in);
    assign w_mem_hit_b = mem_regwrite_in && (mem_regwraddr_in == ex_regrdaddr2_in);
    assign w_wb_hit_a  = wb_regwrite_in  && (wb_regwraddr_in  == ex_regrdaddr1_in);
    assign w_wb_hit_b  = wb_regwrite_in  && (wb_regwraddr_in  == ex_regrdaddr2_in);

    assign w_fwd_a = w_mem_hit_a ? mem_regwrdata_in : (w_wb_hit_a ? wb_regwrdata_in : ex_reg_1);
    assign w_fwd_b = w_mem_hit_b ? mem_regwrdata_in : (w_wb_hit_b ? wb_regwrdata_in : ex_reg_2);
    assign w_opb   = ex_alusrc ? ex_imm : w_fwd_b;

    assign w_load_use = ex_valid_in && mem_memread_in && (w_mem_hit_a || w_mem_hit_b);

    always_comb begin
        w_alu_res = '0;
        w_ovf     = 1'b0;
        case (ex_aluop)
            L_ADD: begin
                w_alu_res = w_fwd_a + w_opb;
                w_ovf     = (w_fwd_a[MSB] == w_opb[MSB]) && (w_alu_res[MSB] != w_fwd_a[MSB]);
            end
            L_SUB: begin
                w_alu_res = w_fwd_a - w_opb;
                w_ovf     = (w_fwd_a[MSB] != w_opb[MSB]) && (w_alu_res[MSB] != w_fwd_a[MSB]);
            end
            L_AND:   w_alu_res = w_fwd_a & w_opb;
            L_OR:    w_alu_res = w_fwd_a | w_opb;
            L_XOR:   w_alu_res = w_fwd_a ^ w_opb;
            L_SLL:   w_alu_res = w_fwd_a << w_opb[SH_W-1:0];
            L_SRL:   w_alu_res = w_fwd_a >> w_opb[SH_W-1:0];
            L_SRA:   w_alu_res = DATA_W'($signed(w_fwd_a) >>> w_opb[SH_W-1:0]);
            L_PASSB: w_alu_res = w_opb;
            default: w_alu_res = '0;
        endcase
    end

    assign w_res       = w_mul_done ? w_mul_prod : w_alu_res;
    assign w_flag_mask = flag_mask((ex_aluop == L_ADD) || (ex_aluop == L_SUB),
                                   ex_memread_in || ex_memwrite_in);

    always_comb begin
        w_flag_calc         = '0;
        w_flag_calc[FLAG_Z] = (w_res == '0);
        w_flag_calc[FLAG_V] = w_ovf;
        w_flag_calc[FLAG_N] = w_res[MSB];
    end

    assign w_flag_nxt = (r_flag & ~w_flag_mask) | (w_flag_calc & w_flag_mask);

`ifdef EX_MUL_EN
    localparam logic [OP_W-1:0] L_MUL = OP_W'(OP_MUL);

    ex_state_t r_state, w_state_nxt;
    logic      w_mul_last, w_mul_accept;

    assign w_is_mul     = (ex_aluop == L_MUL);
    assign w_mul_busy   = (r_state == BUSY);
    assign w_mul_accept = ex_valid_in && w_is_mul && !w_load_use && !w_mul_busy && !ex_flush_in;
    assign w_mul_done   = w_mul_busy && w_mul_last;
    assign w_mul_stall  = w_mul_accept || (w_mul_busy && !w_mul_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ex_flush_in) begin
            w_state_nxt = IDLE;
        end else if (!mem_stall_in) begin
            case (r_state)
                IDLE:    if (w_mul_accept) w_state_nxt = BUSY;
                BUSY:    if (w_mul_last)   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    ex_iter_mul #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_accept && !mem_stall_in),
        .i_step  (w_mul_busy && !mem_stall_in && !ex_flush_in),
        .i_clr   (ex_flush_in),
        .i_a     (w_fwd_a),
        .i_b     (w_opb),
        .o_last  (w_mul_last),
        .o_prod  (w_mul_prod)
    );
`else
    assign w_is_mul    = 1'b0;
    assign w_mul_busy  = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_mul_stall = 1'b0;
    assign w_mul_prod  = '0;
`endif

    assign ex_stall_out = rst_n && !ex_flush_in && (mem_stall_in || w_load_use || w_mul_stall);

    // While a multiply is in flight ID/EX is frozen, so its controls are still on the inputs at done
    assign w_take = w_mul_done || (ex_valid_in && !w_load_use && !w_mul_busy && !w_is_mul);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_bustoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alu      <= '0;
            r_src2     <= '0;
            r_wraddr   <= '0;
            r_flag     <= '0;
        end else if (ex_flush_in) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_bustoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (!mem_stall_in) begin
            r_valid    <= w_take;
            r_regwrite <= w_take && ex_regwrite_in;
            r_memtoreg <= w_take && ex_memtoreg_in;
            r_bustoreg <= w_take && ex_bustoreg_in;
            r_memread  <= w_take && ex_memread_in;
            r_memwrite <= w_take && ex_memwrite_in;
            if (w_take) begin
                r_alu    <= w_res;
                r_src2   <= w_fwd_b;
                r_wraddr <= ex_regwraddr_in;
                r_flag   <= w_flag_nxt;
            end
        end
    end

    assign ex_valid_out     = r_valid;
    assign ex_regwrite_out  = r_regwrite;
    assign ex_memtoreg_out  = r_memtoreg;
    assign ex_bustoreg_out  = r_bustoreg;
    assign ex_memread_out   = r_memread;
    assign ex_memwrite_out  = r_memwrite;
    assign ex_alu_out       = r_alu;
    assign ex_alu_src2_out  = r_src2;
    assign ex_regwraddr_out = r_wraddr;
    assign ex_flag_out      = r_flag;

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised successor to the 16-bit execute stage. It sits between the ID/EX and EX/MEM pipeline registers and provides:
- two-level operand forwarding (MEM over WB) with load-use stall detection
- the single-cycle ALU and a flag register
- an optional iterative multi-cycle multiplier with a stall handshake
- registered EX/MEM outputs with valid, stall and flush control

Parameters:
DATA_W, 16, datapath width (even, ≥8)
REG_AW, 4, register address width
OP_W, 5, ALU opcode width
MUL_BITS, 4, multiplier bits retired per cycle; must divide DATA_W; MUL_LAT = DATA_W/MUL_BITS

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
ex_valid_in  in  1  ID/EX holds a real instruction
ex_flush_in  in  1  kill EX content, emit bubble
mem_stall_in  in  1  downstream hold
ex_aluop  in  OP_W  ALU opcode
ex_alusrc  in  1  1: operand B = ex_imm
ex_reg_1 / ex_reg_2  in  DATA_W  register-file read data
ex_imm  in  DATA_W  sign-extended immediate
ex_regrdaddr1_in / ex_regrdaddr2_in  in  REG_AW  source addresses (A / B)
ex_regwraddr_in  in  REG_AW  destination address
ex_regwrite_in, ex_memtoreg_in, ex_bustoreg_in, ex_memread_in, ex_memwrite_in  in  1  control
mem_regwrite_in, mem_memread_in  in  1  EX/MEM control
mem_regwraddr_in  in  REG_AW  EX/MEM destination
mem_regwrdata_in  in  DATA_W  EX/MEM ALU result
wb_regwrite_in  in  1  MEM/WB write enable
wb_regwraddr_in  in  REG_AW  MEM/WB destination
wb_regwrdata_in  in  DATA_W  MEM/WB write data
ex_stall_out  out  1  hold ID/EX (comb)
ex_valid_out  out  1  EX/MEM valid
ex_flag_out  out  3  {Z,V,N}
ex_regwrite_out, ex_memtoreg_out, ex_bustoreg_out, ex_memread_out, ex_memwrite_out  out  1  registered control
ex_alu_out  out  DATA_W  registered result
ex_alu_src2_out  out  DATA_W  forwarded operand B (store data)
ex_regwraddr_out  out  REG_AW  registered destination

Behaviour:
Reset:
- Every output register, the flag register and the FSM clear to 0/IDLE asynchronously on rst_n low.
- ex_stall_out is 0 during reset.

Forwarding (per source, comb):
- Match on MEM if mem_regwrite_in and mem_regwraddr_in equals the source address.
- Otherwise match on WB if wb_regwrite_in and the addresses are equal.
- Otherwise use register-file data.
- MEM has priority; register 0 is not special-cased.
- Operand B uses ex_imm when ex_alusrc=1.
- ex_alu_src2_out always carries the forwarded reg-2 value.

Load-use:
- A MEM match with mem_memread_in=1 and ex_valid_in=1 raises ex_stall_out for that cycle and registers a bubble.

Bubble:
- ex_valid_out=0 and all write/mem controls 0.
- Data registers hold their previous values.

Normal op:
- Latency is 1: the result registers on the edge after presentation when no stall and no flush.

FSM (EX_MUL_EN only): states IDLE, BUSY.
- IDLE→BUSY: ex_valid_in, aluop==OP_MUL, no flush, no load-use stall.
  - Captures the forwarded operands and clears the counter.
  - ex_stall_out=1 in the accepting cycle and in every BUSY cycle except the last.
- BUSY: adds MUL_BITS partial products per cycle; the counter increments.
  - At count==MUL_LAT-1, the low DATA_W bits of the product register with valid=1 and the FSM returns to IDLE.
- Total MUL latency is MUL_LAT+1 edges from acceptance. Bubbles are emitted while busy.

mem_stall_in=1:
- All registers, the FSM and the counter hold.
- ex_stall_out=1.

ex_flush_in=1:
- Overrides both stalls.
- FSM→IDLE, counter cleared, bubble registered.
- ex_stall_out=0.

Flags:
- Update only on an edge that registers a valid instruction.
- OP_ADD/OP_SUB: Z, V (signed overflow), N.
- Other ALU ops and MUL: Z only.
- memread/memwrite instructions: no update.

Arithmetic:
- Two's complement, wrap at DATA_W; overflow is never saturated.

Optional Feature:
EX_MUL_EN
- Defined: multiplier, FSM and OP_MUL support are present.
- Undefined: OP_MUL yields a 0 result, Z updates, ex_stall_out is driven only by load-use/mem_stall_in, and no multiplier logic exists.

Decomposition:
- Package ex_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, ...), an ex_state_t enum, flag bit indices, and a flag-update-mask function.
- One sub-module ex_iter_mul: operand capture, partial-product accumulation, counter, done pulse.

Test Plan:
1. Back-to-back forwarding: MEM writes r3=0x0005 while WB writes r3=0x0009; ADD r3+r3 → ex_alu_out=0x000A (MEM wins).
2. Load-use: mem_memread_in=1, mem_regwraddr=r2, EX reads r2 → ex_stall_out=1 for exactly one cycle, then one bubble (ex_valid_out=0).
3. MUL 0x0123×0x0010 (DATA_W=16, MUL_BITS=4) → stall for 4 cycles, result 0x1230 with valid on the 5th edge, Z=0.
4. Overflow: ADD 0x7FFF+0x0001 → ex_alu_out=0x8000, flags {Z,V,N}={0,1,1}; a following store leaves the flags unchanged.
5. Flush mid-MUL (2nd BUSY cycle) → FSM IDLE, ex_stall_out=0, bubble next edge, no flag change.
6. Reset asserted mid-MUL with mem_stall_in=1 → all outputs 0 immediately; after release, an ADD completes in 1 cycle.
